l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

- Two-port round-robin arbiter that shares the single L2 cache request interface between the L1 instruction cache (port 0) and the L1 data cache (port 1).
- Latches the granted request, drives the L2 read/write strobes, and returns the L2 block and a one-cycle acknowledge to the winning port.
- Watchdog: aborts any L2 transaction that never completes.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, byte address width.
- L1_BLOCK_SIZE, 16, words per L1 block transferred.
- TIMEOUT_CYCLES, 64, maximum cycles in BUSY before abort; must be ≥2 (8-bit counter).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_addr, p1_addr  in  ADDR_WIDTH  request address; held stable until ack.
- p0_wdata, p1_wdata  in  [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  write block.
- p0_read, p0_write, p1_read, p1_write  in  1  level requests; held until ack.
- p0_rdata, p1_rdata  out  [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  returned block; valid with ack.
- p0_ack, p1_ack  out  1  one-cycle completion pulse.
- p0_err, p1_err  out  1  qualifies ack: transaction aborted by watchdog.
- l2_cache_addr  out  ADDR_WIDTH  latched address to L2.
- l2_cache_data_in  out  [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  latched write block to L2.
- l2_cache_read, l2_cache_write  out  1  L2 strobes.
- l2_cache_data_out  in  [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  L2 return block.
- l2_cache_ready  in  1  L2 completion pulse.
- busy  out  1  state != IDLE.
- l2_timeout  out  1  sticky watchdog flag.

## Operation
- States: IDLE, BUSY, RESP.
- Request from port n = pn_read | pn_write. If both read and write are set on one port, the operation is a write.
- IDLE:
  - No request: stay.
  - Request present: grant, latch addr/wdata/op/grant_id into registers, clear the watchdog counter, go to BUSY.
  - Arbitration: a single requester wins. With both requesting, the port not equal to last_grant wins. last_grant updates on every grant.
- BUSY:
  - l2_cache_read = (op==read) & !l2_cache_ready; l2_cache_write = (op==write) & !l2_cache_ready. Both are combinational from state and the op register and are 0 in every other state.
  - Watchdog counter increments every BUSY cycle.
  - l2_cache_ready sampled 1: capture l2_cache_data_out into the granted pn_rdata, set pn_ack=1 and pn_err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with ready still 0: pn_rdata=0, pn_ack=1, pn_err=1, l2_timeout set, go to RESP. If ready and timeout coincide, ready wins.
- RESP: ack/err are high for exactly this cycle, then clear; go to IDLE unconditionally. This state keeps a requester's still-high request from being re-granted. The requester must drop its request on the edge where it samples ack high.
- The non-granted port's request is held pending; it is never dropped or acked.
- pn_rdata holds its value until the next completion for that port.
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All ack/err/strobes/busy/l2_timeout = 0.
  - All rdata, l2_cache_addr, l2_cache_data_in = 0.
  - Watchdog counter = 0.
- Reset mid-transaction: the transaction is dropped with no ack, and the strobes fall asynchronously with state.

## Timing
- Grant latency:
  - Request visible before edge T0 → BUSY from T0.
  - l2_cache_read/write high during cycle T0..T1.
- L2 ready high in cycle after edge E:
  - Strobe forced low in that same cycle, so L2 returning to IDLE does not retrigger.
  - Arbiter enters RESP at E+1, ack high E+1..E+2, IDLE at E+2.
  - Earliest next grant at edge E+3, so back-to-back transactions are separated by 2 idle strobe cycles.
- Minimum arbiter overhead: 3 cycles beyond L2 service time.
- Watchdog abort: ack asserted TIMEOUT_CYCLES edges after the grant edge.

## Test plan
- Port 0 read, addr 0x0000_0100, L2 ready after 6 cycles returning block word[i]=i:
  - l2_cache_read high for exactly 6 cycles.
  - p0_ack for 1 cycle, p0_rdata word[3]=3, p1_ack=0.
- p0_read and p1_write asserted in the same cycle after reset, then repeated:
  - First grant port 0, then port 1.
  - On the next simultaneous pair, port 0 wins again (alternation).
- p1_write, addr 0x0000_2040, wdata word[i]=0xA5A5_0000+i:
  - l2_cache_write high, l2_cache_addr=0x0000_2040, data_in word[15]=0xA5A5_000F.
  - p1_ack with p1_err=0.
- L2 never asserts ready, TIMEOUT_CYCLES=64:
  - p0_ack with p0_err=1 exactly 64 cycles after the grant.
  - p0_rdata=0, l2_timeout=1 and stays 1 until rst.
- rst pulsed 3 cycles into BUSY:
  - l2_cache_read drops immediately, busy=0, no ack.
  - After release, port 0 wins a tie.
- Requester holds p0_read one cycle past ack (violating the drop rule):
  - Arbiter re-grants from IDLE as a new transaction, never from RESP.
  - Check no grant edge falls within RESP.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares one L2 cache request interface between two L1 caches:
//   port 0 = L1 instruction cache, port 1 = L1 data cache.
// A request is granted from IDLE with round-robin tie-breaking. The address,
// write block and operation are latched, the L2 read or write strobe is
// driven while BUSY, and the returned block is handed back to the winner with
// a one-cycle ack. A watchdog aborts any L2 transaction that never completes
// and reports the abort through the err qualifier and a sticky timeout flag.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   p0_* / p1_*          per-port request side
//     addr, wdata        request address and write block, stable until ack
//     read, write        level requests, held until ack (write wins if both)
//     rdata              returned block, valid with ack, held until the next
//                        completion for that port
//     ack, err           one-cycle completion pulse; err marks a watchdog abort
//   l2_cache_*           L2 side
//     addr, data_in      latched request address and write block
//     read, write        strobes, high while BUSY until l2_cache_ready
//     data_out, ready    returned block and completion pulse from L2
//   busy                 arbiter is not IDLE
//   l2_timeout           sticky watchdog flag, cleared only by rst
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int L1_BLOCK_SIZE  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,

    input  logic [ADDR_WIDTH-1:0]                    p0_addr,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p0_wdata,
    input  logic                                     p0_read,
    input  logic                                     p0_write,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p0_rdata,
    output logic                                     p0_ack,
    output logic                                     p0_err,

    input  logic [ADDR_WIDTH-1:0]                    p1_addr,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p1_wdata,
    input  logic                                     p1_read,
    input  logic                                     p1_write,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p1_rdata,
    output logic                                     p1_ack,
    output logic                                     p1_err,

    output logic [ADDR_WIDTH-1:0]                    l2_cache_addr,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
    output logic                                     l2_cache_read,
    output logic                                     l2_cache_write,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
    input  logic                                     l2_cache_ready,

    output logic                                     busy,
    output logic                                     l2_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    // Last watchdog count value before the abort fires. The counter is
    // cleared on the grant edge and advances on every BUSY edge, so the
    // abort lands exactly TIMEOUT_CYCLES edges after the grant.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic                    last_grant;
    logic                    grant_id;
    logic                    op_write;
    logic [7:0]              wd_cnt;

    // Arbitration, evaluated every cycle but only acted on in IDLE.
    logic                    req0;
    logic                    req1;
    logic                    grant_valid;
    logic                    grant_sel;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    block_t                  sel_wdata;

    assign req0        = p0_read | p0_write;
    assign req1        = p1_read | p1_write;
    assign grant_valid = req0 | req1;

    always_comb begin
        // NOTE: every signal gets a default before any branch so this block
        // can never infer a latch when a case or if path leaves it unassigned.
        grant_sel = 1'b0;
        if (req0 && req1) begin
            // Tie: the port that did not win last time goes now.
            grant_sel = ~last_grant;
        end else if (req1) begin
            grant_sel = 1'b1;
        end

        // Write takes precedence when a port raises both read and write.
        sel_write = grant_sel ? p1_write : p0_write;
        sel_addr  = grant_sel ? p1_addr  : p0_addr;
        sel_wdata = grant_sel ? p1_wdata : p0_wdata;
    end

    // Strobes are decoded straight from state so that a reset drops them
    // immediately, and they fall in the same cycle ready arrives so L2 does
    // not see a second request while it returns to idle.
    assign l2_cache_read  = (state == BUSY) && !op_write && !l2_cache_ready;
    assign l2_cache_write = (state == BUSY) &&  op_write && !l2_cache_ready;
    assign busy           = (state != IDLE);

    // NOTE: state and every output register use non-blocking assignments so
    // all of them update together on the edge and read consistent old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            grant_id         <= 1'b0;
            op_write         <= 1'b0;
            wd_cnt           <= 8'd0;
            p0_ack           <= 1'b0;
            p0_err           <= 1'b0;
            p1_ack           <= 1'b0;
            p1_err           <= 1'b0;
            l2_timeout       <= 1'b0;
            // NOTE: the wide data registers are reset as well, so every
            // returned block and the L2 request lines read as zero until the
            // first transfer instead of carrying undefined values.
            p0_rdata         <= '0;
            p1_rdata         <= '0;
            l2_cache_addr    <= '0;
            l2_cache_data_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_id         <= grant_sel;
                        last_grant       <= grant_sel;
                        op_write         <= sel_write;
                        l2_cache_addr    <= sel_addr;
                        l2_cache_data_in <= sel_wdata;
                        wd_cnt           <= 8'd0;
                        state            <= BUSY;
                    end
                end

                BUSY: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    // Ready is checked first so a completion on the abort
                    // cycle still returns good data.
                    if (l2_cache_ready) begin
                        if (grant_id) begin
                            p1_rdata <= l2_cache_data_out;
                            p1_ack   <= 1'b1;
                            p1_err   <= 1'b0;
                        end else begin
                            p0_rdata <= l2_cache_data_out;
                            p0_ack   <= 1'b1;
                            p0_err   <= 1'b0;
                        end
                        state <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        if (grant_id) begin
                            p1_rdata <= '0;
                            p1_ack   <= 1'b1;
                            p1_err   <= 1'b1;
                        end else begin
                            p0_rdata <= '0;
                            p0_ack   <= 1'b1;
                            p0_err   <= 1'b1;
                        end
                        l2_timeout <= 1'b1;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    // One cycle of ack; passing through here also gives the
                    // winner time to drop its request before IDLE samples it.
                    p0_ack <= 1'b0;
                    p0_err <= 1'b0;
                    p1_ack <= 1'b0;
                    p1_err <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int TO = 64;

    typedef logic [BS-1:0][DW-1:0] block_t;

    typedef struct {
        logic p0_read;
        logic p0_write;
        logic p1_read;
        logic p1_write;
        logic exp_port;
        logic exp_write;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] p0_addr, p1_addr;
    block_t        p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic [AW-1:0] l2_cache_addr;
    block_t        l2_cache_data_in, l2_cache_data_out;
    logic          l2_cache_read, l2_cache_write, l2_cache_ready;
    logic          busy, l2_timeout;

    int tests = 0;
    int fails = 0;

    l2_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L1_BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .l2_cache_addr(l2_cache_addr), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_read(l2_cache_read), .l2_cache_write(l2_cache_write),
        .l2_cache_data_out(l2_cache_data_out), .l2_cache_ready(l2_cache_ready),
        .busy(busy), .l2_timeout(l2_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Step to just after the next rising edge; inputs are driven and outputs
    // sampled here, clear of the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic block_t make_block(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < BS; i++) b[i] = base + 32'(i);
        return b;
    endfunction

    task automatic clear_requests();
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_requests();
        l2_cache_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Return one L2 block for the current transaction and step into RESP.
    task automatic l2_complete(input logic [31:0] base);
        l2_cache_data_out = make_block(base);
        l2_cache_ready = 1'b1;
        tick();
        l2_cache_ready = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected it to end");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int ack_edge;
        logic [31:0] b0, b1;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        p0_addr = '0; p1_addr = '0;
        p0_wdata = '0; p1_wdata = '0;
        l2_cache_data_out = '0;
        do_reset();

        // ---------------- reset state ----------------
        check("rst_busy", busy, 0);
        check("rst_strobes", {l2_cache_read, l2_cache_write}, 0);
        check("rst_ack_err", {p0_ack, p0_err, p1_ack, p1_err}, 0);
        check("rst_timeout", l2_timeout, 0);
        check("rst_l2_addr", l2_cache_addr, 0);
        check("rst_data_in_zero", l2_cache_data_in == '0, 1);
        check("rst_rdata_zero", (p0_rdata == '0) && (p1_rdata == '0), 1);

        // ---------------- port 0 read, L2 ready after 6 cycles ----------------
        p0_addr = 32'h0000_0100;
        p0_read = 1'b1;
        tick();
        check("rd_addr", l2_cache_addr, 32'h0000_0100);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (l2_cache_read) cnt++;
            tick();
        end
        l2_cache_data_out = make_block(32'h0);
        l2_cache_ready = 1'b1;
        #1;
        if (l2_cache_read) cnt++;
        tick();
        l2_cache_ready = 1'b0;
        if (l2_cache_read) cnt++;
        check("rd_strobe_cycles", cnt, 6);
        check("rd_p0_ack", {p0_ack, p0_err}, 2'b10);
        check("rd_p1_ack", p1_ack, 0);
        check("rd_word3", p0_rdata[3], 3);
        p0_read = 1'b0;
        tick();
        check("rd_ack_one_cycle", p0_ack, 0);

        // ---------------- port 1 write ----------------
        p1_addr = 32'h0000_2040;
        p1_wdata = make_block(32'hA5A5_0000);
        p1_write = 1'b1;
        tick();
        check("wr_strobes", {l2_cache_read, l2_cache_write}, 2'b01);
        check("wr_addr", l2_cache_addr, 32'h0000_2040);
        check("wr_data15", l2_cache_data_in[15], 32'hA5A5_000F);
        l2_complete(32'h0);
        check("wr_p1_ack_err", {p1_ack, p1_err}, 2'b10);
        check("wr_p0_ack", p0_ack, 0);
        p1_write = 1'b0;
        tick();

        // ---------------- watchdog abort ----------------
        p0_addr = 32'h0000_0300;
        p0_read = 1'b1;
        tick();
        ack_edge = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (p0_ack) begin
                ack_edge = k;
                break;
            end
        end
        check("to_ack_edge", ack_edge, TO);
        check("to_err", p0_err, 1);
        check("to_rdata_zero", p0_rdata == '0, 1);
        check("to_flag", l2_timeout, 1);
        check("to_p1_ack", p1_ack, 0);
        p0_read = 1'b0;
        tick();
        check("to_ack_clear", p0_ack, 0);
        // Flag stays set across a later good transaction.
        p1_read = 1'b1;
        tick();
        l2_complete(32'h7700_0000);
        check("to_next_ok", {p1_ack, p1_err}, 2'b10);
        p1_read = 1'b0;
        tick();
        check("to_flag_sticky", l2_timeout, 1);
        rst = 1'b1;
        #1;
        check("to_flag_rst", l2_timeout, 0);
        tick();
        rst = 1'b0;

        // ---------------- reset 3 cycles into BUSY ----------------
        p0_addr = 32'h0000_0400;
        p1_addr = 32'h0000_0500;
        p0_read = 1'b1;
        tick();
        tick();
        tick();
        check("mid_read_high", l2_cache_read, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_read_low", l2_cache_read, 0);
        check("mid_rst_busy", busy, 0);
        p0_read = 1'b0;
        tick();
        check("mid_rst_no_ack", {p0_ack, p1_ack}, 0);
        rst = 1'b0;
        p0_read = 1'b1;
        p1_write = 1'b1;
        tick();
        check("mid_tie_addr", l2_cache_addr, 32'h0000_0400);
        check("mid_tie_strobes", {l2_cache_read, l2_cache_write}, 2'b10);
        l2_complete(32'h1100_0000);
        check("mid_p0_ack", {p0_ack, p1_ack}, 2'b10);
        p0_read = 1'b0;
        tick();
        tick();
        // The held port 1 request is served next from IDLE.
        check("pend_addr", l2_cache_addr, 32'h0000_0500);
        check("pend_strobes", {l2_cache_read, l2_cache_write}, 2'b01);
        l2_complete(32'h2200_0000);
        check("pend_p1_ack", {p0_ack, p1_ack}, 2'b01);
        p1_write = 1'b0;
        tick();

        // ---------------- request held one cycle past ack ----------------
        p0_addr = 32'h0000_0600;
        p0_read = 1'b1;
        tick();
        l2_complete(32'h3300_0000);
        check("hold_ack", p0_ack, 1);
        tick();
        check("hold_no_grant_in_resp", busy, 0);
        check("hold_ack_clear", p0_ack, 0);
        tick();
        check("hold_regrant_busy", busy, 1);
        check("hold_regrant_read", l2_cache_read, 1);
        l2_complete(32'h4400_0000);
        p0_read = 1'b0;
        tick();

        // ---------------- arbitration table ----------------
        do_reset();
        foreach (vecs[i]) begin
            b0 = 32'h5000_0000 + 32'(i * 256);
            b1 = 32'h6000_0000 + 32'(i * 256);
            p0_addr  = 32'h0000_1000 + 32'(i * 16);
            p1_addr  = 32'h0000_2000 + 32'(i * 16);
            p0_wdata = make_block(b0);
            p1_wdata = make_block(b1);
            p0_read  = vecs[i].p0_read;
            p0_write = vecs[i].p0_write;
            p1_read  = vecs[i].p1_read;
            p1_write = vecs[i].p1_write;
            tick();
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_strobes", i), {l2_cache_read, l2_cache_write},
                  vecs[i].exp_write ? 2'b01 : 2'b10);
            check($sformatf("v%0d_addr", i), l2_cache_addr,
                  vecs[i].exp_port ? p1_addr : p0_addr);
            check($sformatf("v%0d_data_in2", i), l2_cache_data_in[2],
                  (vecs[i].exp_port ? b1 : b0) + 32'd2);
            l2_cache_data_out = make_block(32'hD000_0000 + 32'(i * 256));
            l2_cache_ready = 1'b1;
            #1;
            check($sformatf("v%0d_strobe_drop", i), {l2_cache_read, l2_cache_write}, 0);
            tick();
            l2_cache_ready = 1'b0;
            check($sformatf("v%0d_ack", i), {p0_ack, p1_ack}, vecs[i].exp_port ? 2'b01 : 2'b10);
            check($sformatf("v%0d_rdata5", i),
                  vecs[i].exp_port ? p1_rdata[5] : p0_rdata[5], 32'hD000_0005 + 32'(i * 256));
            clear_requests();
            tick();
            check($sformatf("v%0d_idle", i), {busy, p0_ack, p1_ack, p0_err, p1_err}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
